mem_ctrl: RTL and testbench

Memory controller directly downstream of the `riscv` core top. It takes the core's 32-bit instruction-fetch port (`rom_*`) and data port (`ram_*`) and arbitrates them onto one byte-wide synchronous external memory. It assembles or splits words over multiple cycles and returns one-cycle completion pulses. While an access is outstanding it raises stall requests so the core's `ctrl` block can freeze the pipeline.

---
 rtl/mem_ctrl_pkg.sv | 49 ++++
 rtl/mem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        MemIdle = 2'd0,
        MemRd   = 2'd1,
        MemWr   = 2'd2,
        MemDone = 2'd3
    } mem_state_e;

    // Which core port owns the access in flight.
    localparam logic OWN_ROM = 1'b0;
    localparam logic OWN_RAM = 1'b1;

    // Last counter value of each sequence: a read needs one extra cycle
    // because the external byte arrives one cycle after its address.
    localparam logic [2:0] RD_LAST_CNT = 3'd4;
    localparam logic [2:0] WR_LAST_CNT = 3'd3;

    // Pick byte lane 'lane' out of a little-endian word.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Replace byte lane 'lane' of a word with 'b'.
    function automatic logic [31:0] put_lane(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            2'd3:    r[31:24] = b;
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates the core's fetch and data ports onto one byte-wide synchronous
// memory, assembling/splitting 32-bit words over four byte cycles.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    output logic              rom_done_o,
    input  logic              ram_ce_i,
    input  logic              ram_we_i,
    input  logic [31:0]       ram_addr_i,
    input  logic [3:0]        ram_sel_i,
    input  logic [31:0]       ram_data_i,
    output logic [31:0]       ram_data_o,
    output logic              ram_done_o,
    output logic              stallreq_if_o,
    output logic              stallreq_mem_o,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic [7:0]        mem_dout_o,
    output logic              mem_wr_o,
    input  logic [7:0]        mem_din_i
);

    mem_state_e        r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_base, w_base_nxt;
    logic              r_owner, w_owner_nxt;
    logic [31:0]       r_asm, w_asm_nxt;
    logic [ADDR_W-1:0] r_mem_a, w_mem_a_nxt;
    logic [7:0]        r_mem_dout, w_mem_dout_nxt;
    logic              r_mem_wr, w_mem_wr_nxt;
    logic [31:0]       r_rom_data, w_rom_data_nxt;
    logic [31:0]       r_ram_data, w_ram_data_nxt;
    logic              r_rom_done, w_rom_done_nxt;
    logic              r_ram_done, w_ram_done_nxt;

    logic [ADDR_W-1:0] w_rom_base, w_ram_base;
    logic [2:0]        w_cnt_inc, w_cnt_dec;
    logic [ADDR_W-1:0] w_addr_inc;
    logic              w_unused;

    // Word-aligned bases and the byte offset helpers used by the sequencer.
    assign w_rom_base = {rom_addr_i[ADDR_W-1:2], 2'b00};
    assign w_ram_base = {ram_addr_i[ADDR_W-1:2], 2'b00};
    assign w_cnt_inc  = r_cnt + 3'd1;
    assign w_cnt_dec  = r_cnt - 3'd1;
    assign w_addr_inc = {r_base[ADDR_W-1:2], w_cnt_inc[1:0]};
    // Address bits above the external range and the byte offset are don't-care.
    assign w_unused   = ^{rom_addr_i[31:ADDR_W], rom_addr_i[1:0],
                          ram_addr_i[31:ADDR_W], ram_addr_i[1:0], r_base[1:0]};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= MemIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: arbitration, byte sequencing and completion values.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_base_nxt     = r_base;
        w_owner_nxt    = r_owner;
        w_asm_nxt      = r_asm;
        w_mem_a_nxt    = r_mem_a;
        w_mem_dout_nxt = r_mem_dout;
        w_mem_wr_nxt   = 1'b0;
        w_rom_data_nxt = r_rom_data;
        w_ram_data_nxt = r_ram_data;
        w_rom_done_nxt = 1'b0;
        w_ram_done_nxt = 1'b0;
        case (r_state)
            MemIdle: begin
                // Data port wins over fetch; first byte address goes out now.
                if (ram_ce_i) begin
                    w_owner_nxt = OWN_RAM;
                    w_base_nxt  = w_ram_base;
                    w_mem_a_nxt = w_ram_base;
                    w_cnt_nxt   = 3'd0;
                    if (ram_we_i) begin
                        w_state_nxt    = MemWr;
                        w_mem_dout_nxt = lane_byte(ram_data_i, 2'd0);
                        w_mem_wr_nxt   = ram_sel_i[0];
                    end else begin
                        w_state_nxt = MemRd;
                    end
                end else if (rom_ce_i) begin
                    w_owner_nxt = OWN_ROM;
                    w_base_nxt  = w_rom_base;
                    w_mem_a_nxt = w_rom_base;
                    w_cnt_nxt   = 3'd0;
                    w_state_nxt = MemRd;
                end else begin
                    w_state_nxt = MemIdle;
                end
            end
            MemRd: begin
                // Byte for base+cnt-1 is on mem_din_i while cnt is 1..4.
                if (r_cnt != 3'd0) begin
                    w_asm_nxt = put_lane(r_asm, w_cnt_dec[1:0], mem_din_i);
                end else begin
                    w_asm_nxt = r_asm;
                end
                if (r_cnt < WR_LAST_CNT) begin
                    w_mem_a_nxt = w_addr_inc;
                end else begin
                    w_mem_a_nxt = r_mem_a;
                end
                if (r_cnt == RD_LAST_CNT) begin
                    w_state_nxt = MemDone;
                    w_cnt_nxt   = 3'd0;
                    if (r_owner == OWN_RAM) begin
                        w_ram_data_nxt = w_asm_nxt;
                        w_ram_done_nxt = 1'b1;
                    end else begin
                        w_rom_data_nxt = w_asm_nxt;
                        w_rom_done_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            MemWr: begin
                // Lanes with a clear select still take their cycle, strobe low.
                if (r_cnt < WR_LAST_CNT) begin
                    w_mem_a_nxt    = w_addr_inc;
                    w_mem_dout_nxt = lane_byte(ram_data_i, w_cnt_inc[1:0]);
                    w_mem_wr_nxt   = ram_sel_i[w_cnt_inc[1:0]];
                    w_cnt_nxt      = w_cnt_inc;
                end else begin
                    w_state_nxt    = MemDone;
                    w_cnt_nxt      = 3'd0;
                    w_ram_done_nxt = 1'b1;
                end
            end
            MemDone: begin
                w_state_nxt = MemIdle;
            end
            default: begin
                w_state_nxt = MemIdle;
            end
        endcase
    end

    // Sequencer and output registers; reset clears every visible output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= 3'd0;
            r_base     <= '0;
            r_owner    <= OWN_ROM;
            r_asm      <= 32'h0000_0000;
            r_mem_a    <= '0;
            r_mem_dout <= 8'h00;
            r_mem_wr   <= 1'b0;
            r_rom_data <= 32'h0000_0000;
            r_ram_data <= 32'h0000_0000;
            r_rom_done <= 1'b0;
            r_ram_done <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_base     <= w_base_nxt;
            r_owner    <= w_owner_nxt;
            r_asm      <= w_asm_nxt;
            r_mem_a    <= w_mem_a_nxt;
            r_mem_dout <= w_mem_dout_nxt;
            r_mem_wr   <= w_mem_wr_nxt;
            r_rom_data <= w_rom_data_nxt;
            r_ram_data <= w_ram_data_nxt;
            r_rom_done <= w_rom_done_nxt;
            r_ram_done <= w_ram_done_nxt;
        end
    end

    assign rom_data_o     = r_rom_data;
    assign rom_done_o     = r_rom_done;
    assign ram_data_o     = r_ram_data;
    assign ram_done_o     = r_ram_done;
    assign mem_a_o        = r_mem_a;
    assign mem_dout_o     = r_mem_dout;
    assign mem_wr_o       = r_mem_wr;
    assign stallreq_if_o  = rom_ce_i & ~r_rom_done;
    assign stallreq_mem_o = ram_ce_i & ~r_ram_done;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed plus randomized bench for mem_ctrl with a byte-array memory
// and a word-level reference model of memory contents.
module tb_mem_ctrl;
    localparam int AW = 17;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rom_ce_i = 1'b0;
    logic [31:0]   rom_addr_i = 32'h0;
    logic [31:0]   rom_data_o;
    logic          rom_done_o;
    logic          ram_ce_i = 1'b0;
    logic          ram_we_i = 1'b0;
    logic [31:0]   ram_addr_i = 32'h0;
    logic [3:0]    ram_sel_i = 4'h0;
    logic [31:0]   ram_data_i = 32'h0;
    logic [31:0]   ram_data_o;
    logic          ram_done_o;
    logic          stallreq_if_o;
    logic          stallreq_mem_o;
    logic [AW-1:0] mem_a_o;
    logic [7:0]    mem_dout_o;
    logic          mem_wr_o;
    logic [7:0]    mem_din_i;

    logic [7:0]    mem [0:MSZ-1];
    logic [7:0]    ref_mem [0:MSZ-1];
    int            n_cmp = 0;
    int            n_fail = 0;
    int            wr_pulses = 0;
    logic [AW-1:0] last_wr_a;
    logic [7:0]    last_wr_d;
    logic [31:0]   exp_rom_data = 32'h0;

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i), .rom_data_o(rom_data_o), .rom_done_o(rom_done_o),
        .ram_ce_i(ram_ce_i), .ram_we_i(ram_we_i), .ram_addr_i(ram_addr_i), .ram_sel_i(ram_sel_i),
        .ram_data_i(ram_data_i), .ram_data_o(ram_data_o), .ram_done_o(ram_done_o),
        .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
        .mem_a_o(mem_a_o), .mem_dout_o(mem_dout_o), .mem_wr_o(mem_wr_o), .mem_din_i(mem_din_i)
    );

    always #5 clk = ~clk;

    // Synchronous external memory: read data one cycle after the address.
    always @(posedge clk) begin
        mem_din_i <= mem[mem_a_o];
        if (mem_wr_o) begin
            mem[mem_a_o] <= mem_dout_o;
            wr_pulses    <= wr_pulses + 1;
            last_wr_a    <= mem_a_o;
            last_wr_d    <= mem_dout_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int word_base(input logic [31:0] a);
        return int'(a[AW-1:0]) & ~3;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b = word_base(a);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [3:0] sel, input logic [31:0] d);
        int b = word_base(a);
        for (int k = 0; k < 4; k++)
            if (sel[k]) ref_mem[b+k] = d[8*k +: 8];
    endtask

    // Count cycles (sampled on falling edges) until the chosen done pulse.
    task automatic wait_done(input bit want_ram, output int lat, output bit stall_ok,
                             output bit stall_at_done, output bit other_seen);
        bit seen = 1'b0;
        lat = 99; stall_ok = 1'b1; stall_at_done = 1'b1; other_seen = 1'b0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            @(negedge clk);
            if (want_ram ? ram_done_o : rom_done_o) begin
                seen = 1'b1; lat = i;
                stall_at_done = want_ram ? stallreq_mem_o : stallreq_if_o;
            end else begin
                if (!(want_ram ? stallreq_mem_o : stallreq_if_o)) stall_ok = 1'b0;
                if (want_ram ? rom_done_o : ram_done_o) other_seen = 1'b1;
            end
        end
    endtask

    // One isolated access: kind 0 = fetch, 1 = load, 2 = store.
    task automatic access(input string tag, input int kind, input logic [31:0] a,
                          input logic [3:0] sel, input logic [31:0] d);
        int lat; bit sok, sad, oth; int wp0; int b;
        @(negedge clk);
        wp0 = wr_pulses;
        if (kind == 0) begin
            rom_ce_i = 1'b1; rom_addr_i = a;
        end else begin
            ram_ce_i = 1'b1; ram_we_i = (kind == 2); ram_addr_i = a; ram_sel_i = sel; ram_data_i = d;
        end
        wait_done(kind != 0, lat, sok, sad, oth);
        check({tag, "_lat"}, lat, (kind == 2) ? 5 : 6);
        check({tag, "_stall_busy"}, {31'd0, sok}, 32'd1);
        check({tag, "_stall_done"}, {31'd0, sad}, 32'd0);
        check({tag, "_other_done"}, {31'd0, oth}, 32'd0);
        if (kind == 0) begin
            exp_rom_data = ref_word(a);
            check({tag, "_rom_data"}, rom_data_o, exp_rom_data);
        end else begin
            check({tag, "_rom_hold"}, rom_data_o, exp_rom_data);
            if (kind == 1) begin
                check({tag, "_ram_data"}, ram_data_o, ref_word(a));
            end else begin
                ref_store(a, sel, d);
                check({tag, "_wr_count"}, wr_pulses - wp0, $countones(sel));
                b = word_base(a);
                check({tag, "_mem_word"}, {mem[b+3], mem[b+2], mem[b+1], mem[b]}, ref_word(a));
            end
        end
        rom_ce_i = 1'b0; ram_ce_i = 1'b0; ram_we_i = 1'b0;
        @(negedge clk);
        check({tag, "_done_clear"}, {30'd0, rom_done_o, ram_done_o}, 32'd0);
    endtask

    initial begin
        int lat; bit sok, sad, oth; int wp0;
        logic [31:0] a1, a2, d;
        for (int i = 0; i < MSZ; i++) begin
            d[7:0] = 8'($urandom);
            mem[i] = d[7:0]; ref_mem[i] = d[7:0];
        end
        mem[16'h10] = 8'h13; mem[16'h11] = 8'h05; mem[16'h12] = 8'h10; mem[16'h13] = 8'h00;
        ref_mem[16'h10] = 8'h13; ref_mem[16'h11] = 8'h05; ref_mem[16'h12] = 8'h10; ref_mem[16'h13] = 8'h00;

        // Reset state.
        #12;
        check("rst_outputs", {rom_data_o ^ ram_data_o}, 32'h0);
        check("rst_mem_if", {14'd0, mem_a_o, mem_dout_o}, 32'h0);
        check("rst_flags", {27'd0, rom_done_o, ram_done_o, mem_wr_o, stallreq_if_o, stallreq_mem_o}, 32'h0);
        @(negedge clk); rst = 1'b1;

        // Fetch of a known instruction word.
        access("fetch10", 0, 32'h10, 4'h0, 32'h0);
        check("fetch10_const", rom_data_o, 32'h0010_0513);

        // Single-lane store.
        wp0 = wr_pulses;
        access("st_sel4", 2, 32'h20, 4'b0100, 32'hAABB_CCDD);
        check("st_sel4_pulses", wr_pulses - wp0, 1);
        check("st_sel4_addr", {15'd0, last_wr_a}, 32'h22);
        check("st_sel4_data", {24'd0, last_wr_d}, 32'hBB);

        // Simultaneous fetch and load: data first, fetch 7 cycles later.
        a1 = 32'h0000_0100; a2 = 32'h0000_0204;
        @(negedge clk);
        rom_ce_i = 1'b1; rom_addr_i = a1; ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = a2;
        wait_done(1'b1, lat, sok, sad, oth);
        check("both_ram_lat", lat, 6);
        check("both_no_rom_first", {31'd0, oth}, 32'd0);
        check("both_ram_data", ram_data_o, ref_word(a2));
        check("both_if_stalled", {31'd0, stallreq_if_o}, 32'd1);
        ram_ce_i = 1'b0;
        wait_done(1'b0, lat, sok, sad, oth);
        check("both_rom_gap", lat, 7);
        check("both_rom_stall", {31'd0, sok}, 32'd1);
        exp_rom_data = ref_word(a1);
        check("both_rom_data", rom_data_o, exp_rom_data);
        rom_ce_i = 1'b0;
        @(negedge clk);

        // Unaligned load address: low bits ignored.
        access("ld33", 1, 32'h33, 4'h0, 32'h0);

        // Asynchronous reset in the middle of a read, request held across it.
        a1 = 32'h0001_2344;
        @(negedge clk);
        rom_ce_i = 1'b1; rom_addr_i = a1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_mem_a", {15'd0, mem_a_o}, 32'h0);
        check("arst_dout_wr", {23'd0, mem_dout_o, mem_wr_o}, 32'h0);
        check("arst_rom_data", rom_data_o, 32'h0);
        check("arst_ram_data", ram_data_o, 32'h0);
        check("arst_done", {30'd0, rom_done_o, ram_done_o}, 32'h0);
        exp_rom_data = 32'h0;
        @(negedge clk); rst = 1'b1;
        wait_done(1'b0, lat, sok, sad, oth);
        check("arst_restart_lat", lat, 6);
        exp_rom_data = ref_word(a1);
        check("arst_restart_data", rom_data_o, exp_rom_data);
        rom_ce_i = 1'b0;
        @(negedge clk);

        // Request held through DONE: no re-issue during DONE.
        a2 = 32'h0000_0ABC;
        @(negedge clk);
        ram_ce_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = a2;
        wait_done(1'b1, lat, sok, sad, oth);
        check("held_ld_first", lat, 6);
        wait_done(1'b1, lat, sok, sad, oth);
        check("held_ld_second", lat, 7);
        check("held_ld_data", ram_data_o, ref_word(a2));
        ram_we_i = 1'b1; ram_sel_i = 4'b1111; ram_data_i = 32'h1234_5678;
        ram_ce_i = 1'b0;
        @(negedge clk);
        ram_ce_i = 1'b1; ram_addr_i = 32'h0000_0400;
        wait_done(1'b1, lat, sok, sad, oth);
        check("held_st_first", lat, 5);
        wait_done(1'b1, lat, sok, sad, oth);
        check("held_st_second", lat, 6);
        ref_store(32'h0000_0400, 4'b1111, 32'h1234_5678);
        ram_ce_i = 1'b0; ram_we_i = 1'b0;
        @(negedge clk);
        access("held_st_readback", 1, 32'h0000_0400, 4'h0, 32'h0);
        check("held_st_value", ram_data_o, 32'h1234_5678);

        // Randomized mix of fetches, loads and stores.
        for (int it = 0; it < 24; it++) begin
            access("rand", int'($urandom_range(0, 2)), $urandom, 4'($urandom_range(0, 15)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
